// File: rtl/demux_1_to_4.sv
// -----------------------------------------------------------------------------
// demux_1_to_4
//
// Purpose
//   Routes a single data bit I to one of four registered outputs Y[3:0], as
//   chosen by sel. A select change is applied break-before-make: on the edge
//   where sel differs from the applied select, every output is driven to
//   IDLE_LEVEL for one cycle, the new select is latched and `switching`
//   pulses high. On the next edge with sel stable, I is routed to the newly
//   selected output. No input reaches an output without passing a register.
//
// Optional feature
//   `DEMUX_1_TO_4_ACTIVITY_CNT_EN` -- when defined, adds four saturating
//   CNT_W-bit activity counters (one per output) that count 0->1 transitions
//   of the registered Y bits, plus a synchronous clear input. When undefined
//   the counters and their ports do not exist.
//
// Parameters
//   IDLE_LEVEL  level on deselected outputs, and on all outputs during reset
//               and during the switching cycle
//   CNT_W       width of each activity counter (counter build only)
//
// Ports
//   clk        in   1        single clock, rising edge
//   rst        in   1        synchronous active-high reset, overrides all inputs
//   I          in   1        data bit to be routed
//   sel        in   2        requested output index 0..3
//   Y          out  4        registered routed outputs
//   sel_q      out  2        currently applied select
//   switching  out  1        one-cycle pulse on the edge a select change applies
//   cnt_clr    in   1        synchronous clear of all counters (counter build)
//   cnt        out  4*CNT_W  counter n at bits [n*CNT_W +: CNT_W] (counter build)
// -----------------------------------------------------------------------------
module demux_1_to_4 #(
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             I,
  input  logic [1:0]       sel,
  output logic [3:0]       Y,
  output logic [1:0]       sel_q,
  output logic             switching
`ifdef DEMUX_1_TO_4_ACTIVITY_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [4*CNT_W-1:0] cnt
`endif
);

  // Guard against a meaningless counter width in either build.
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("demux_1_to_4: CNT_W must be at least 1");
  end

  localparam logic [3:0] ALL_IDLE = {4{IDLE_LEVEL}};

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic [3:0] r_y;
  logic [1:0] r_sel_q;
  logic       r_switching;

  // ---------------------------------------------------------------------------
  // Combinational routing for the stable-select case
  // ---------------------------------------------------------------------------
  logic [3:0] w_y_route;
  logic       w_sel_change;

  // NOTE: every always_comb output gets a default on its first line, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_y_route          = ALL_IDLE;
    w_y_route[r_sel_q] = I;
  end

  assign w_sel_change = (sel != r_sel_q);

  // ---------------------------------------------------------------------------
  // Routing register. A select change blanks all outputs for the edge it is
  // applied on, so a deselected output never sees I, even transiently.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned only with <=, so every register samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-high here; it is the first branch
    // so it overrides sel and I with no partial update on that edge.
    if (rst) begin
      r_y         <= ALL_IDLE;
      r_sel_q     <= 2'd0;
      r_switching <= 1'b0;
    end else if (w_sel_change) begin
      r_y         <= ALL_IDLE;
      r_sel_q     <= sel;
      r_switching <= 1'b1;
    end else begin
      r_y         <= w_y_route;
      r_switching <= 1'b0;
    end
  end

  assign Y         = r_y;
  assign sel_q     = r_sel_q;
  assign switching = r_switching;

`ifdef DEMUX_1_TO_4_ACTIVITY_CNT_EN
  // ---------------------------------------------------------------------------
  // Activity counters. A rising transition is detected on the registered Y
  // against its value one cycle earlier, so a count lands one edge after the
  // Y bit itself goes high.
  // ---------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0] r_y_d;
  logic [3:0] w_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_d <= ALL_IDLE;
    end else begin
      r_y_d <= r_y;
    end
  end

  assign w_rise = r_y & ~r_y_d;

  for (genvar n = 0; n < 4; n++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;

    // Clear beats increment; a full counter holds rather than wrapping.
    always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
        r_cnt <= '0;
      end else if (w_rise[n] && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign cnt[n*CNT_W +: CNT_W] = r_cnt;
  end
`endif

endmodule

// File: tb/tb_demux_1_to_4.sv
// -----------------------------------------------------------------------------
// tb_demux_1_to_4
//
// Drives directed and randomized traffic into demux_1_to_4. For every edge the
// driver computes the expected outputs from the behavioural rules (select
// change blanks and pulses switching, stable select routes I) and pushes them
// into a scoreboard queue; an independent monitor pops one entry per edge and
// compares it with the DUT outputs. Counter expectations are included when the
// bench is built with DEMUX_1_TO_4_ACTIVITY_CNT_EN.
// -----------------------------------------------------------------------------
module tb_demux_1_to_4;

  localparam int   CNT_W      = 4;
  localparam logic IDLE_LEVEL = 1'b0;
  localparam int   CNT_MAX    = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 I;
  logic [1:0]           sel;
  logic [3:0]           Y;
  logic [1:0]           sel_q;
  logic                 switching;
  logic                 cnt_clr;
  logic [4*CNT_W-1:0]   cnt;

  always #5 clk = ~clk;

  demux_1_to_4 #(
    .IDLE_LEVEL (IDLE_LEVEL),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .I         (I),
    .sel       (sel),
    .Y         (Y),
    .sel_q     (sel_q),
    .switching (switching)
`ifdef DEMUX_1_TO_4_ACTIVITY_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .cnt       (cnt)
`endif
  );

`ifndef DEMUX_1_TO_4_ACTIVITY_CNT_EN
  assign cnt = '0;
`endif

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0]         y;
    logic [1:0]         selq;
    logic               sw;
    logic [4*CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time,
               actual, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: state after the most recent edge
  // ---------------------------------------------------------------------------
  int         m_selq = 0;
  logic [3:0] m_y    = 4'b0000;
  logic [3:0] m_y_d  = 4'b0000;
  int         m_cnt[4] = '{0, 0, 0, 0};
  int         rises_routed[4] = '{0, 0, 0, 0};

  // Apply one clock edge with the given inputs: present them on the falling
  // edge, advance the model and queue the expected post-edge outputs.
  task automatic step(input logic r, input int s, input logic i, input logic c);
    exp_t e;
    logic [3:0] y_new;
    @(negedge clk);
    rst = r; sel = 2'(s); I = i; cnt_clr = c;

    if (r) begin
      m_selq = 0;
      m_y    = {4{IDLE_LEVEL}};
      m_y_d  = {4{IDLE_LEVEL}};
      for (int n = 0; n < 4; n++) m_cnt[n] = 0;
      e.sw = 1'b0;
    end else begin
      // Counters see the transition already visible on Y (previous edge).
      for (int n = 0; n < 4; n++) begin
        if (c) m_cnt[n] = 0;
        else if (m_y[n] && !m_y_d[n] && m_cnt[n] < CNT_MAX) m_cnt[n]++;
      end
      y_new = {4{IDLE_LEVEL}};
      if (s != m_selq) begin
        m_selq = s;
        e.sw   = 1'b1;
      end else begin
        y_new[m_selq] = i;
        e.sw = 1'b0;
      end
      for (int n = 0; n < 4; n++)
        if (y_new[n] && !m_y[n]) rises_routed[n]++;
      m_y_d = m_y;
      m_y   = y_new;
    end

    e.y    = m_y;
    e.selq = 2'(m_selq);
    for (int n = 0; n < 4; n++) e.cnt[n*CNT_W +: CNT_W] = CNT_W'(m_cnt[n]);
    sb_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: one expected entry per edge, compared shortly after the edge
  // ---------------------------------------------------------------------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("Y",         64'(Y),         64'(e.y));
        check("sel_q",     64'(sel_q),     64'(e.selq));
        check("switching", 64'(switching), 64'(e.sw));
`ifdef DEMUX_1_TO_4_ACTIVITY_CNT_EN
        check("cnt",       64'(cnt),       64'(e.cnt));
`endif
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : driver
    logic i_lvl;
    int   s;
    rst = 1'b1; sel = 2'd0; I = 1'b0; cnt_clr = 1'b0;

    // Reset for two cycles with noisy inputs: reset must override them.
    step(1'b1, 3, 1'b1, 1'b0);
    step(1'b1, 2, 1'b1, 1'b0);

    // sel held at 0, I toggling every 4 cycles.
    i_lvl = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k % 4 == 0) i_lvl = ~i_lvl;
      step(1'b0, 0, i_lvl, 1'b0);
    end

    // sel 0 -> 1 with I = 1: one blank switching cycle, then Y = 4'b0010.
    for (int k = 0; k < 4; k++) step(1'b0, 1, 1'b1, 1'b0);

    // sel stepped 0,1,2,3 every 40 cycles with I toggling every 3 cycles.
    for (int k = 0; k < 160; k++) begin
      if (k % 3 == 0) i_lvl = ~i_lvl;
      step(1'b0, k / 40, i_lvl, 1'b0);
    end

    // Select changing on consecutive edges keeps outputs blank.
    for (int k = 0; k < 6; k++) step(1'b0, k % 4, 1'b1, 1'b0);
    step(1'b0, 1, 1'b1, 1'b0);
    step(1'b0, 1, 1'b1, 1'b0);

    // Clear, then 20+ rising edges on Y[2] to saturate a 4-bit counter,
    // then a clear held across a rising transition.
    step(1'b0, 2, 1'b0, 1'b1);
    for (int k = 0; k < 44; k++) step(1'b0, 2, 1'(k % 2), 1'b0);
    step(1'b0, 2, 1'b1, 1'b1);
    step(1'b0, 2, 1'b0, 1'b1);
    step(1'b0, 2, 1'b1, 1'b0);
    step(1'b0, 2, 1'b0, 1'b0);

    // Reset asserted exactly while switching is high.
    step(1'b0, 3, 1'b1, 1'b0);
    step(1'b1, 3, 1'b1, 1'b0);
    // First edge after reset with sel != 0 is a select change.
    step(1'b0, 2, 1'b1, 1'b0);
    step(1'b0, 2, 1'b1, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0);
    // First edge after reset with sel == 0 routes immediately.
    step(1'b0, 0, 1'b1, 1'b0);

    // Randomized traffic: sporadic select changes, random data, rare reset
    // and clear.
    s = 0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(7) == 0) s = int'($urandom_range(3));
      step(($urandom_range(63) == 0), s, 1'($urandom_range(1)),
           ($urandom_range(31) == 0));
    end

    // Settle so late counter updates are observed, then drain.
    for (int k = 0; k < 3; k++) step(1'b0, s, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared,
             n_mismatched);
    $finish;
  end

endmodule
